// File: rtl/demux1x4_nbit_buffered.sv
// demux1x4_nbit_buffered
//   Routes a single valid/ready input stream to one of four output channels.
//   Each channel has a one-entry holding register with its own valid/ready
//   handshake. The destination is s when auto=0, or a round-robin pointer
//   when auto=1. The pointer advances only on beats accepted with auto=1.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   x [N-1:0]      input data beat
//   x_valid        input beat present
//   x_ready        input accepted this cycle if x_valid (combinational)
//   s [1:0]        destination channel when auto=0
//   auto           1: destination = round-robin pointer, 0: destination = s
//   z0..z3 [N-1:0] registered channel data
//   v0..v3         registered channel valid
//   r0..r3         channel consumer ready
//   dst [1:0]      current destination (combinational)
`timescale 1ns/1ps
module demux1x4_nbit_buffered #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] x,
  input  logic         x_valid,
  output logic         x_ready,
  input  logic [1:0]   s,
  input  logic         auto,
  output logic [N-1:0] z0,
  output logic [N-1:0] z1,
  output logic [N-1:0] z2,
  output logic [N-1:0] z3,
  output logic         v0,
  output logic         v1,
  output logic         v2,
  output logic         v3,
  input  logic         r0,
  input  logic         r1,
  input  logic         r2,
  input  logic         r3,
  output logic [1:0]   dst
);

  logic [3:0][N-1:0] z_q;
  logic [3:0]        v_q;
  logic [3:0]        r_vec;
  logic [1:0]        ptr;
  logic              accept;

  assign r_vec = {r3, r2, r1, r0};

  // x_ready looks only at the destination channel, so a stalled channel
  // never blocks beats headed elsewhere. rst_n gates it so that nothing is
  // accepted while reset is held.
  always_comb begin
    dst     = auto ? ptr : s;
    x_ready = rst_n & (~v_q[dst] | r_vec[dst]);
    accept  = x_valid & x_ready;
  end

  // A load takes priority over a drain in the same cycle. That keeps v set
  // and lets a channel sustain one beat per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= '0;
      v_q <= '0;
      ptr <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (accept && (dst == 2'(i))) begin
          z_q[i] <= x;
          v_q[i] <= 1'b1;
        end else if (v_q[i] && r_vec[i]) begin
          v_q[i] <= 1'b0;
        end
      end
      if (accept && auto) begin
        ptr <= ptr + 2'd1;
      end
    end
  end

  assign z0 = z_q[0];
  assign z1 = z_q[1];
  assign z2 = z_q[2];
  assign z3 = z_q[3];
  assign v0 = v_q[0];
  assign v1 = v_q[1];
  assign v2 = v_q[2];
  assign v3 = v_q[3];

endmodule

// File: tb/tb_demux1x4_nbit_buffered.sv
`timescale 1ns/1ps
module tb_demux1x4_nbit_buffered;

  logic       clk;
  logic       rst_n;
  logic [3:0] x;
  logic       x_valid;
  logic       x_ready;
  logic [1:0] s;
  logic       au;
  logic [3:0] z0, z1, z2, z3;
  logic       v0, v1, v2, v3;
  logic [3:0] r;
  logic [1:0] dst;

  logic [3:0] zz [4];
  logic [3:0] vv;
  logic [3:0] exp_q [4][$];

  int checks   = 0;
  int failures = 0;

  demux1x4_nbit_buffered #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .x(x), .x_valid(x_valid), .x_ready(x_ready),
    .s(s), .auto(au),
    .z0(z0), .z1(z1), .z2(z2), .z3(z3),
    .v0(v0), .v1(v1), .v2(v2), .v3(v3),
    .r0(r[0]), .r1(r[1]), .r2(r[2]), .r3(r[3]),
    .dst(dst)
  );

  assign zz[0] = z0;
  assign zz[1] = z1;
  assign zz[2] = z2;
  assign zz[3] = z3;
  assign vv    = {v3, v2, v1, v0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one beat right after a rising edge, confirm it is acceptable
  // mid-cycle, record it, and drop x_valid after the accepting edge.
  task automatic send(input logic [3:0] d, input logic [1:0] sel,
                      input logic a, input logic [1:0] ch);
    @(posedge clk); #1;
    x = d; s = sel; au = a; x_valid = 1'b1;
    @(negedge clk);
    chk("send_ready", int'(x_ready), 1);
    chk("send_dst", int'(dst), int'(ch));
    exp_q[ch].push_back(d);
    @(posedge clk); #1;
    x_valid = 1'b0;
  endtask

  task automatic check_out(input logic [1:0] ch, input logic [3:0] d);
    @(negedge clk);
    chk($sformatf("v%0d_valid", ch), int'(vv[ch]), 1);
    chk($sformatf("z%0d_data", ch), int'(zz[ch]), int'(d));
  endtask

  // Scoreboard: every completed channel handshake consumes the oldest
  // expected beat for that channel.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (vv[i] && r[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("ch%0d_unexpected", i), 1, 0);
          end else begin
            chk($sformatf("ch%0d_sb", i), int'(zz[i]), int'(exp_q[i].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a beat presented.
    rst_n = 1'b0; x = 4'd9; x_valid = 1'b1; s = 2'd2; au = 1'b1; r = 4'b1111;
    #2;
    chk("rst_x_ready", int'(x_ready), 0);
    chk("rst_v", int'(vv), 0);
    chk("rst_z0", int'(z0), 0);
    chk("rst_z3", int'(z3), 0);
    chk("rst_ptr_dst", int'(dst), 0);
    au = 1'b0; #1;
    chk("rst_dst_s", int'(dst), 2);
    x_valid = 1'b0;
    #10;
    rst_n = 1'b1;

    // Select routing.
    send(4'd3, 2'd0, 1'b0, 2'd0);  check_out(2'd0, 4'd3);
    send(4'd5, 2'd1, 1'b0, 2'd1);  check_out(2'd1, 4'd5);
    send(4'd7, 2'd2, 1'b0, 2'd2);  check_out(2'd2, 4'd7);
    send(4'd11, 2'd3, 1'b0, 2'd3); check_out(2'd3, 4'd11);

    // Round-robin with wrap.
    send(4'd2, 2'd3, 1'b1, 2'd0);
    send(4'd4, 2'd3, 1'b1, 2'd1);
    send(4'd6, 2'd3, 1'b1, 2'd2);
    send(4'd10, 2'd3, 1'b1, 2'd3);
    send(4'd1, 2'd3, 1'b1, 2'd0);
    check_out(2'd0, 4'd1);
    chk("rr_ptr_end", int'(dst), 1);

    // Backpressure on channel 1.
    r = 4'b1101;
    send(4'd5, 2'd1, 1'b0, 2'd1);
    check_out(2'd1, 4'd5);
    @(posedge clk); #1;
    x = 4'd9; s = 2'd1; x_valid = 1'b1;
    @(negedge clk);
    chk("bp_blocked_ready", int'(x_ready), 0);
    chk("bp_v1_held", int'(v1), 1);
    @(posedge clk); #1;
    x = 4'd7; s = 2'd2;
    @(negedge clk);
    chk("bp_other_ready", int'(x_ready), 1);
    exp_q[2].push_back(4'd7);
    @(posedge clk); #1;
    x = 4'd9; s = 2'd1; r = 4'b1111;
    @(negedge clk);
    chk("bp_release_ready", int'(x_ready), 1);
    chk("bp_z1_still5", int'(z1), 5);
    chk("bp_v2", int'(v2), 1);
    chk("bp_z2", int'(z2), 7);
    exp_q[1].push_back(4'd9);
    @(posedge clk); #1;
    x_valid = 1'b0;
    @(negedge clk);
    chk("bp_v1_stays", int'(v1), 1);
    chk("bp_z1_new", int'(z1), 9);

    // Full throughput on channel 0.
    @(posedge clk); #1;
    for (int k = 1; k <= 8; k++) begin
      x = 4'(k); s = 2'd0; au = 1'b0; x_valid = 1'b1;
      @(negedge clk);
      chk("tp_ready", int'(x_ready), 1);
      if (k > 1) begin
        chk("tp_v0", int'(v0), 1);
        chk("tp_z0", int'(z0), k - 1);
      end
      exp_q[0].push_back(4'(k));
      @(posedge clk); #1;
    end
    x_valid = 1'b0;
    @(negedge clk);
    chk("tp_last_z0", int'(z0), 8);

    // Mid-operation reset with ptr=2 and channel 2 holding data.
    send(4'd13, 2'd0, 1'b1, 2'd1);
    r = 4'b1011;
    send(4'd12, 2'd2, 1'b0, 2'd2);
    au = 1'b1; #1;
    chk("mr_pre_ptr", int'(dst), 2);
    chk("mr_pre_v2", int'(v2), 1);
    @(negedge clk); #2;
    x = 4'd6; x_valid = 1'b1;
    rst_n = 1'b0; #1;
    chk("mr_v2", int'(v2), 0);
    chk("mr_z2", int'(z2), 0);
    chk("mr_ptr", int'(dst), 0);
    chk("mr_ready", int'(x_ready), 0);
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    x_valid = 1'b0; r = 4'b1111;
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mr_release_v", int'(vv), 0);
    send(4'd14, 2'd3, 1'b1, 2'd0);
    check_out(2'd0, 4'd14);

    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sb_empty_ch%0d", i), exp_q[i].size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
